// File: rtl/horner_term_sequencer_pkg.sv
// horner_term_sequencer_pkg: shared widths, FSM encoding and reciprocal-constant helper
package horner_term_sequencer_pkg;
    localparam int W_DEF    = 32;
    localparam int FRAC_DEF = 16;
    typedef enum logic [1:0] {IDLE, RUN, WAIT, DONE} state_e;
    function automatic logic [63:0] recip(input int k, input int frac);
        return (k == 0) ? 64'd0 : (64'd1 << frac) / 64'(k);
    endfunction
endpackage

// File: rtl/horner_term_sequencer_recip_lut.sv
// recip_lut: combinational ROM mapping k to floor(2^FRAC/k), zero outside 1..N_TERMS
module recip_lut
    import horner_term_sequencer_pkg::*;
#(
    parameter int N_TERMS = 8,
    parameter int W       = W_DEF,
    parameter int FRAC    = FRAC_DEF,
    localparam int IW     = $clog2(N_TERMS) + 1
) (
    input  logic [IW-1:0] k_i,
    output logic [W-1:0]  c_o
);
    logic [W-1:0] rom [2**IW];
    for (genvar i = 0; i < 2**IW; i++) begin : g_rom
        assign rom[i] = (i >= 1 && i <= N_TERMS) ? W'(recip(i, FRAC)) : '0;
    end
    assign c_o = rom[k_i];
endmodule

// File: rtl/horner_term_sequencer.sv
// horner_term_sequencer: drives a shared registered MAC stage through N_TERMS Horner steps per operand
module horner_term_sequencer
    import horner_term_sequencer_pkg::*;
#(
    parameter int N_TERMS = 8,
    parameter int W       = W_DEF,
    parameter int FRAC    = FRAC_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_x,
    output logic [W-1:0] drv_prev,
    output logic [W-1:0] drv_x,
    output logic [W-1:0] drv_const,
    input  logic [W-1:0] stage_out,
    input  logic         stage_ovf,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_ovf
);
    localparam int IW = $clog2(N_TERMS) + 1;

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  x_q, x_d;
    logic          ovf_q, ovf_d;
    logic [W-1:0]  data_q, data_d;
    logic          oovf_q, oovf_d;
    logic [W-1:0]  lut_c;

    recip_lut #(.N_TERMS(N_TERMS), .W(W), .FRAC(FRAC)) u_lut (
        .k_i(IW'(N_TERMS) - idx_q),
        .c_o(lut_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            x_q     <= '0;
            ovf_q   <= 1'b0;
            data_q  <= '0;
            oovf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            ovf_q   <= ovf_d;
            data_q  <= data_d;
            oovf_q  <= oovf_d;
        end
    end

    // drv_* are combinational so each term sees the previous result the cycle it appears
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        x_d       = x_q;
        ovf_d     = ovf_q;
        data_d    = data_q;
        oovf_d    = oovf_q;
        drv_prev  = '0;
        drv_x     = '0;
        drv_const = '0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = in_x;
                    idx_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                drv_x     = x_q;
                drv_const = lut_c;
                drv_prev  = (idx_q == '0) ? '0 : stage_out;
                ovf_d     = ovf_q | ((idx_q != '0) & stage_ovf);
                idx_d     = idx_q + IW'(1);
                state_d   = (idx_q == IW'(N_TERMS - 1)) ? WAIT : RUN;
            end
            WAIT: begin
                data_d  = stage_out;
                oovf_d  = ovf_q | stage_ovf;
                state_d = DONE;
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = data_q;
    assign out_ovf   = oovf_q;
endmodule

// File: doc/horner_term_sequencer.md
Name: horner_term_sequencer

Overview:
Producer/controller side of the Horner series datapath. It accepts an operand x over a valid/ready handshake and, for each term, drives one shared registered MAC stage (prev*x + constant) with prev, x and the reciprocal constant 1/k. It feeds each stage result back as the next prev and returns the final sum with a sticky overflow flag over a valid/ready output handshake. It sits between the operand source and the series-approximation consumer, and owns the term count and the 1/k constant table.

Parameters:
N_TERMS, 8, number of Horner terms (constants 1/N_TERMS down to 1/1), range 2..16
W, 32, data width, signed two's complement
FRAC, 16, fractional bits (Q16.16 at defaults)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
in_valid  in  1  operand x offered
in_ready  out  1  sequencer can accept x
in_x  in  W  operand x
drv_prev  out  W  prev operand to MAC stage
drv_x  out  W  x operand to MAC stage
drv_const  out  W  1/k constant to MAC stage
stage_out  in  W  registered MAC result; 1-cycle latency from drv_*
stage_ovf  in  1  registered MAC overflow, aligned with stage_out
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_data  out  W  final series value
out_ovf  out  1  sticky OR of stage_ovf over this job's results

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, out_ovf=0, drv_prev=drv_x=drv_const=0, idx=0, x_reg=0, ovf_acc=0. The MAC stage shares the same reset.
- States: IDLE, RUN, WAIT, DONE.
- IDLE: in_ready=1. When in_valid=1 at the edge, latch x_reg=in_x, set idx=0, clear ovf_acc, go to RUN.
- RUN: in_ready=0. Each cycle issues one term:
  - drv_x=x_reg.
  - drv_const=LUT(N_TERMS-idx).
  - drv_prev=0 when idx==0, else stage_out (the previous term's result).
  - When idx>=1, ovf_acc |= stage_ovf.
  - idx increments each edge. The edge where idx==N_TERMS-1 goes to WAIT.
- WAIT (one cycle): stage_out holds the final term. At the edge: out_data=stage_out, out_ovf=ovf_acc|stage_ovf, out_valid=1, go to DONE.
- DONE: out_data and out_ovf are held stable while out_valid=1 and out_ready=0. When out_ready=1 at the edge: out_valid=0, go to IDLE. There is no same-cycle re-accept (in_ready=0 in DONE).
- Latency: out_valid rises N_TERMS+1 edges after the accept edge. Throughput is one job per N_TERMS+3 cycles.
- drv_* outside RUN: hold 0. The stage is free-running; results outside a job are ignored.
- Arithmetic: the sequencer does no arithmetic beyond the idx counter (width clog2(N_TERMS)+1). All MAC rounding and overflow belong to the stage.
- LUT(k) = floor(2^FRAC / k) as W-bit unsigned-in-signed, e.g. k=1 0x00010000, k=2 0x00008000, k=3 0x00005555, k=8 0x00002000.
- in_valid while busy: ignored (in_ready=0). x_reg is never overwritten mid-job.
- Reset mid-job (any state): abort immediately to IDLE with reset values. A partial result is never emitted.
- Sticky overflow covers exactly the N_TERMS results of the current job; stage_ovf from a previous job or from idle cycles is excluded.

Decomposition:
- Shared package: FRAC/W defaults, state encoding (IDLE/RUN/WAIT/DONE), the reciprocal-constant function used to build the LUT.
- Sub-module recip_lut: combinational ROM, index k -> floor(2^FRAC/k), sized by N_TERMS, reusable by other series blocks.

Test Plan:
- x=0x00000000, ideal-stage model, out_ready=1 -> out_data=0x00010000 (c_1 only), out_ovf=0, out_valid rises 9 edges after accept.
- x=0x00010000 (1.0) -> out_data=0x0002B7C4 (sum of floor(65536/k), k=1..8), out_ovf=0. Check drv_const sequence 0x2000,0x2492,0x2AAA,0x3333,0x4000,0x5555,0x8000,0x10000 on successive RUN cycles.
- Stage model forces stage_ovf=1 only on the 3rd result -> out_ovf=1. Next job with clean stage -> out_ovf=0; also force stage_ovf=1 during IDLE -> still out_ovf=0.
- Hold out_ready=0 for 5 cycles in DONE with in_valid=1 and a new x -> out_data stable, in_ready=0, new x not accepted until one cycle after the out_ready handshake.
- Assert reset in RUN at idx=4 -> next cycle state IDLE, in_ready=1, out_valid=0, drv_* = 0. A following job with x=0 still yields 0x00010000.
- Back-to-back jobs with in_valid held high and out_ready=1 -> jobs spaced exactly 11 cycles apart, no dropped or duplicated results.
